// File: rtl/baby_store_loader.sv
// Program loader with a 32x32 store: assembles 128 streamed bytes into words, then serves CPU reads/writes in RUN.
// Latency: one cycle per accepted byte (128 to load) and zero-cycle CPU reads; bytes are stalled by load_valid_i and dropped outside LOAD.
module baby_store_loader #(
    parameter logic AUTO_RUN = 1'b1
) (
    input  logic        clock,
    input  logic        reset_i,
    input  logic        load_start_i,
    input  logic        run_i,
    input  logic [7:0]  load_data_i,
    input  logic        load_valid_i,
    output logic        load_ready_o,
    input  logic [4:0]  cpu_addr_i,
    input  logic        cpu_rw_en_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_reset_o,
    output logic        loading_o,
    output logic        load_done_o
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [4:0]  r_word_cnt;
    logic [23:0] r_asm;
    logic [31:0] r_mem [32];
    logic        r_cpu_reset;
    logic        r_load_done;

    always_ff @(posedge clock) begin
        if (reset_i) begin
            r_state     <= ST_HOLD;
            r_byte_cnt  <= 2'd0;
            r_word_cnt  <= 5'd0;
            r_asm       <= 24'd0;
            r_cpu_reset <= 1'b1;
            r_load_done <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                ST_HOLD: begin
                    if (load_start_i) begin
                        r_state    <= ST_LOAD;
                        r_byte_cnt <= 2'd0;
                        r_word_cnt <= 5'd0;
                    end else if (run_i) begin
                        r_state     <= ST_RUN;
                        r_cpu_reset <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_valid_i) begin
                        case (r_byte_cnt)
                            2'd0:    r_asm[7:0]   <= load_data_i;
                            2'd1:    r_asm[15:8]  <= load_data_i;
                            2'd2:    r_asm[23:16] <= load_data_i;
                            default: begin
                                // Last byte of the word goes straight into the store with the held lower bytes.
                                r_mem[r_word_cnt] <= {load_data_i, r_asm};
                                if (r_word_cnt == 5'd31) begin
                                    r_load_done <= 1'b1;
                                    r_state     <= AUTO_RUN ? ST_RUN : ST_HOLD;
                                    r_cpu_reset <= ~AUTO_RUN;
                                end
                            end
                        endcase
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_word_cnt <= r_word_cnt + 5'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cpu_rw_en_i) begin
                        r_mem[cpu_addr_i] <= cpu_data_i;
                    end
                    if (load_start_i) begin
                        r_state     <= ST_LOAD;
                        r_byte_cnt  <= 2'd0;
                        r_word_cnt  <= 5'd0;
                        r_cpu_reset <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_HOLD;
                    r_cpu_reset <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready_o = (r_state == ST_LOAD);
    assign loading_o    = (r_state == ST_LOAD);
    assign cpu_reset_o  = r_cpu_reset;
    assign load_done_o  = r_load_done;
    assign cpu_data_o   = (r_state == ST_RUN) ? r_mem[cpu_addr_i] : 32'd0;

endmodule

// File: tb/tb_baby_store_loader.sv
// Bench for baby_store_loader: AUTO_RUN=1 and AUTO_RUN=0 instances share stimulus and are checked against a byte-level model.
module tb_baby_store_loader;

    logic        clock = 1'b0;
    logic        reset_i, load_start_i, run_i, load_valid_i, cpu_rw_en_i;
    logic [7:0]  load_data_i;
    logic [4:0]  cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [1:0]  ready_v, loading_v, creset_v, done_v;
    logic [31:0] data_a, data_h;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int dc;

    always #5 clock = ~clock;

    baby_store_loader #(.AUTO_RUN(1'b1)) dut_a (
        .clock(clock), .reset_i(reset_i), .load_start_i(load_start_i), .run_i(run_i),
        .load_data_i(load_data_i), .load_valid_i(load_valid_i), .load_ready_o(ready_v[0]),
        .cpu_addr_i(cpu_addr_i), .cpu_rw_en_i(cpu_rw_en_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(data_a), .cpu_reset_o(creset_v[0]), .loading_o(loading_v[0]),
        .load_done_o(done_v[0])
    );

    baby_store_loader #(.AUTO_RUN(1'b0)) dut_h (
        .clock(clock), .reset_i(reset_i), .load_start_i(load_start_i), .run_i(run_i),
        .load_data_i(load_data_i), .load_valid_i(load_valid_i), .load_ready_o(ready_v[1]),
        .cpu_addr_i(cpu_addr_i), .cpu_rw_en_i(cpu_rw_en_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(data_h), .cpu_reset_o(creset_v[1]), .loading_o(loading_v[1]),
        .load_done_o(done_v[1])
    );

    // Model: mode 0=hold 1=load 2=run; a load is a sequence of 128 bytes, word w = bytes 4w..4w+3 little-endian.
    int          m_mode [2];
    int          m_cnt  [2];
    logic        m_done [2];
    logic [7:0]  m_bytes[2][128];
    logic [31:0] m_mem  [2][32];
    int          n;

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset_i) begin
                m_mode[i] = 0;
                m_cnt[i]  = 0;
                m_done[i] = 1'b0;
                for (int w = 0; w < 32; w++) m_mem[i][w] = 32'd0;
            end else begin
                m_done[i] = 1'b0;
                if (m_mode[i] == 0) begin
                    if (load_start_i) begin m_mode[i] = 1; m_cnt[i] = 0; end
                    else if (run_i) m_mode[i] = 2;
                end else if (m_mode[i] == 1) begin
                    if (load_valid_i) begin
                        n = m_cnt[i];
                        m_bytes[i][n] = load_data_i;
                        if (n % 4 == 3)
                            m_mem[i][n / 4] = {m_bytes[i][n], m_bytes[i][n-1], m_bytes[i][n-2], m_bytes[i][n-3]};
                        m_cnt[i] = n + 1;
                        if (m_cnt[i] == 128) begin
                            m_done[i] = 1'b1;
                            m_mode[i] = (i == 0) ? 2 : 0;
                        end
                    end
                end else begin
                    if (cpu_rw_en_i) m_mem[i][cpu_addr_i] = cpu_data_i;
                    if (load_start_i) begin m_mode[i] = 1; m_cnt[i] = 0; end
                end
            end
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d actual=%h required=%h", nm, inst, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("ready", i, {31'd0, ready_v[i]}, {31'd0, m_mode[i] == 1});
                chk("loading", i, {31'd0, loading_v[i]}, {31'd0, m_mode[i] == 1});
                chk("cpu_reset", i, {31'd0, creset_v[i]}, {31'd0, m_mode[i] != 2});
                chk("done", i, {31'd0, done_v[i]}, {31'd0, m_done[i]});
                chk("cpu_data", i, (i == 0) ? data_a : data_h,
                    (m_mode[i] == 2) ? m_mem[i][cpu_addr_i] : 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load();
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
    endtask

    // Streams bytes k = 0..127; returns the cycle count at which dut_a's done pulse was first seen.
    task automatic load_stream(input bit stall, output int done_cyc);
        int cyc;
        cyc = 0;
        done_cyc = -1;
        for (int k = 0; k < 128; k++) begin
            load_valid_i = 1'b1;
            load_data_i  = k[7:0];
            tick();
            cyc++;
            if (done_v[0] && done_cyc < 0) done_cyc = cyc;
            if (stall && k != 127) begin
                load_valid_i = 1'b0;
                tick();
                cyc++;
                if (done_v[0] && done_cyc < 0) done_cyc = cyc;
            end
        end
        load_valid_i = 1'b0;
    endtask

    task automatic sweep_reads();
        for (int a = 0; a < 32; a++) begin
            cpu_addr_i = a[4:0];
            tick();
        end
    endtask

    initial begin
        reset_i = 1'b1; load_start_i = 1'b0; run_i = 1'b0; load_valid_i = 1'b0;
        load_data_i = 8'd0; cpu_addr_i = 5'd0; cpu_rw_en_i = 1'b0; cpu_data_i = 32'd0;
        tick();
        tick();
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_cpu_reset", i, {31'd0, creset_v[i]}, 32'd1);
            chk("rst_ready", i, {31'd0, ready_v[i]}, 32'd0);
            chk("rst_loading", i, {31'd0, loading_v[i]}, 32'd0);
            chk("rst_done", i, {31'd0, done_v[i]}, 32'd0);
        end
        chk("rst_data", 0, data_a, 32'd0);
        reset_i = 1'b0;

        // Bytes offered in HOLD are dropped.
        for (int k = 0; k < 4; k++) begin
            load_valid_i = 1'b1; load_data_i = 8'($urandom); tick();
        end
        load_valid_i = 1'b0;

        start_load();
        load_stream(1'b0, dc);
        chk("full_done_cycle", 0, dc, 128);
        chk("full_cpu_reset_a", 0, {31'd0, creset_v[0]}, 32'd0);
        chk("full_cpu_reset_h", 1, {31'd0, creset_v[1]}, 32'd1);
        cpu_addr_i = 5'd0;  #1; chk("store0", 0, data_a, 32'h03020100);
        cpu_addr_i = 5'd31; #1; chk("store31", 0, data_a, 32'h7F7E7D7C);
        tick();
        chk("done_pulse_end", 0, {31'd0, done_v[0]}, 32'd0);

        cpu_addr_i = 5'd5; cpu_rw_en_i = 1'b1; cpu_data_i = 32'hDEADBEEF;
        tick();
        cpu_rw_en_i = 1'b0;
        #1; chk("cpu_wr5", 0, data_a, 32'hDEADBEEF);
        cpu_addr_i = 5'd6; #1; chk("cpu_rd6", 0, data_a, 32'h1B1A1918);

        chk("hold_cpu_reset", 1, {31'd0, creset_v[1]}, 32'd1);
        run_i = 1'b1; tick(); run_i = 1'b0;
        chk("run_cpu_reset", 1, {31'd0, creset_v[1]}, 32'd0);

        // Bytes offered in RUN are dropped; store must be unchanged.
        for (int k = 0; k < 6; k++) begin
            load_valid_i = 1'b1; load_data_i = 8'($urandom); cpu_addr_i = 5'($urandom); tick();
        end
        load_valid_i = 1'b0;
        sweep_reads();

        start_load();
        load_stream(1'b1, dc);
        chk("stall_done_cycle", 0, dc, 255);
        cpu_addr_i = 5'd0;  #1; chk("stall_store0", 0, data_a, 32'h03020100);
        cpu_addr_i = 5'd5;  #1; chk("stall_store5", 0, data_a, 32'h17161514);
        cpu_addr_i = 5'd31; #1; chk("stall_store31", 0, data_a, 32'h7F7E7D7C);
        run_i = 1'b1; tick(); run_i = 1'b0;
        sweep_reads();

        // Reset after 50 bytes, with a byte still offered during reset.
        start_load();
        for (int k = 0; k < 50; k++) begin
            load_valid_i = 1'b1; load_data_i = k[7:0]; tick();
        end
        reset_i = 1'b1; load_data_i = 8'hAA; tick();
        reset_i = 1'b0; load_valid_i = 1'b0;
        chk("midrst_loading", 0, {31'd0, loading_v[0]}, 32'd0);
        run_i = 1'b1; tick(); run_i = 1'b0;
        cpu_addr_i = 5'd0;  #1; chk("midrst_store0", 0, data_a, 32'd0);
        cpu_addr_i = 5'd12; #1; chk("midrst_store12", 1, data_h, 32'd0);
        sweep_reads();
        start_load();
        load_stream(1'b0, dc);
        chk("reload_done_cycle", 0, dc, 128);
        cpu_addr_i = 5'd31; #1; chk("reload_store31", 0, data_a, 32'h7F7E7D7C);
        run_i = 1'b1; tick(); run_i = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            reset_i      = ($urandom_range(0, 299) == 0);
            load_start_i = ($urandom_range(0, 39) == 0);
            run_i        = ($urandom_range(0, 7) == 0);
            load_valid_i = ($urandom_range(0, 3) != 0);
            load_data_i  = 8'($urandom);
            cpu_addr_i   = 5'($urandom);
            cpu_rw_en_i  = ($urandom_range(0, 3) == 0);
            cpu_data_i   = $urandom;
            tick();
        end
        reset_i = 1'b0; load_start_i = 1'b0; run_i = 1'b0; load_valid_i = 1'b0; cpu_rw_en_i = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baby_store_loader.md
BABY_STORE_LOADER -- requirements
Module: baby_store_loader

Interface
REQ-001 SHALL have parameter: AUTO_RUN, default 1, 1 = enter RUN automatically after a completed load, 0 = return to HOLD and wait for run_i.
REQ-002 SHALL have port: clock  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: load_start_i  in  1  level sampled each cycle; starts a program load.
REQ-005 SHALL have port: run_i  in  1  releases the CPU from HOLD.
REQ-006 SHALL have port: load_data_i  in  8  program byte stream.
REQ-007 SHALL have port: load_valid_i  in  1  load_data_i valid.
REQ-008 SHALL have port: load_ready_o  out  1  loader accepts a byte this cycle.
REQ-009 SHALL have port: cpu_addr_i  in  5  store address from the CPU.
REQ-010 SHALL have port: cpu_rw_en_i  in  1  0 = read, 1 = write.
REQ-011 SHALL have port: cpu_data_i  in  32  write data from the CPU.
REQ-012 SHALL have port: cpu_data_o  out  32  read data to the CPU.
REQ-013 SHALL have port: cpu_reset_o  out  1  held high to keep the CPU in reset.
REQ-014 SHALL have port: loading_o  out  1  high while in LOAD.
REQ-015 SHALL have port: load_done_o  out  1  one-cycle pulse on completion of a load.

Function
REQ-016 SHALL contain a 32-word x 32-bit store.
REQ-017 SHALL implement states HOLD, LOAD and RUN.
REQ-018 SHALL transition HOLD -> LOAD when load_start_i=1, and HOLD -> RUN when run_i=1 and load_start_i=0; load_start_i has priority over run_i.
REQ-019 SHALL transition RUN -> LOAD when load_start_i=1; run_i is ignored in RUN.
REQ-020 SHALL ignore load_start_i and run_i in LOAD.
REQ-021 SHALL clear the byte counter (2 bits) and word counter (5 bits) to 0 on entry to LOAD.
REQ-022 SHALL drive load_ready_o=1 only in LOAD and 0 in HOLD and RUN.
REQ-023 SHALL accept a byte only on a cycle where load_valid_i=1 and load_ready_o=1; bytes offered outside LOAD are dropped, not buffered.
REQ-024 SHALL assemble words little-endian: byte 0 -> bits 7:0, byte 1 -> 15:8, byte 2 -> 23:16, byte 3 -> 31:24.
REQ-025 SHALL, on the edge accepting byte 3, write the assembled word to store[word counter] on that same edge, then increment the word counter and reset the byte counter to 0.
REQ-026 SHALL, on the edge accepting byte 3 of word 31, pulse load_done_o high for exactly the following cycle and leave LOAD for RUN if AUTO_RUN=1, or HOLD if AUTO_RUN=0.
REQ-027 SHALL make load latency exactly 128 accepted bytes; gaps in load_valid_i stall the loader without losing state.
REQ-028 SHALL drive cpu_reset_o=1 in HOLD and LOAD, and 0 only in RUN; cpu_reset_o is registered (changes on the state-change edge).
REQ-029 SHALL drive loading_o=1 exactly when the state is LOAD.
REQ-030 SHALL, in RUN, make cpu_data_o = store[cpu_addr_i] combinationally (asynchronous read, zero-cycle latency), including on write cycles (old data).
REQ-031 SHALL drive cpu_data_o=0 in HOLD and LOAD.
REQ-032 SHALL, in RUN with cpu_rw_en_i=1, write cpu_data_i to store[cpu_addr_i] at the rising edge.
REQ-033 SHALL ignore CPU writes in HOLD and LOAD.
REQ-034 SHALL, in the cycle RUN -> LOAD occurs with cpu_rw_en_i=1, still complete the CPU write, since the state is RUN at that edge.
REQ-035 SHALL write only through the loader during LOAD; there is no simultaneous-write conflict.

Reset
REQ-036 SHALL, with reset_i=1 at an edge, enter HOLD, clear all 32 store words, clear the counters and the assembly register, and set cpu_reset_o=1, load_ready_o=0, loading_o=0, load_done_o=0, cpu_data_o=0.
REQ-037 SHALL, on reset mid-load, discard the partial word and any loaded words, and ignore all bytes presented during reset.

Verification
REQ-038 SHALL cover full load: reset, load_start_i pulse, 128 bytes with byte k = k[7:0] and valid held high -> store[0]=0x03020100, store[31]=0x7F7E7D7C, load_done_o high for one cycle 128 cycles after the first accept, cpu_reset_o falls on the same edge (AUTO_RUN=1).
REQ-039 SHALL cover stalled stream: the same load with load_valid_i toggling 1/0 -> identical store contents, completion after 255 cycles.
REQ-040 SHALL cover CPU access in RUN: write 0xDEADBEEF to addr 5 -> the next cycle's read of addr 5 returns 0xDEADBEEF; the read of addr 6 is unchanged.
REQ-041 SHALL cover reset mid-load: reset after 50 bytes -> HOLD, all store words 0, a following full load is correct.
REQ-042 SHALL cover AUTO_RUN=0: load completes -> HOLD with cpu_reset_o=1; run_i=1 -> RUN next cycle, cpu_reset_o=0.
REQ-043 SHALL cover bytes while not loading: load_valid_i=1 in HOLD/RUN -> load_ready_o=0, store unchanged.
